// File: rtl/mmio_uart_tx_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register offsets, bit indices, FSM states.
// Latency: n/a (package only).
// Backpressure: n/a.
package mmio_uart_tx_pkg;

    // Register offsets from BASE_ADDR
    localparam logic [2:0] OFF_TXDATA = 3'd0;
    localparam logic [2:0] OFF_STATUS = 3'd1;
    localparam logic [2:0] OFF_DIV_LO = 3'd2;
    localparam logic [2:0] OFF_DIV_HI = 3'd3;
    localparam logic [2:0] OFF_CTRL   = 3'd4;

    // STATUS bit indices ([7:4] carry the saturated FIFO count)
    localparam int ST_BUSY  = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_EMPTY = 2;
    localparam int ST_OVF   = 3;

    // CTRL bit indices
    localparam int CTRL_PAR_EN   = 0;
    localparam int CTRL_PAR_ODD  = 1;
    localparam int CTRL_TWO_STOP = 2;
    localparam int CTRL_TX_EN    = 3;

    // Transmitter enabled, 8N1
    localparam logic [3:0] CTRL_RESET = 4'h8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the UART shifter; head byte visible combinationally on dout.
// Latency: a pushed byte is readable on dout the cycle after the push edge.
// Backpressure: push is dropped when full unless a pop happens in the same cycle; pop ignored when empty.
module uart_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_,
    input  logic                       push,
    input  logic [7:0]                 din,
    input  logic                       pop,
    output logic [7:0]                 dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_ok;
    logic          rd_ok;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rd_ok = pop & ~empty;
    // A full FIFO still takes a byte when the head leaves in the same cycle
    assign wr_ok = push & (~full | rd_ok);
    assign dout  = mem[rd_ptr];

    // Storage array; no reset needed, validity is tracked by count
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (!reset_) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr_ok && !rd_ok) begin
                count <= count + CW'(1);
            end else if (rd_ok && !wr_ok) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: byte FIFO, programmable divisor, optional parity, 1/2 stop bits.
// Latency: byte written at edge E0 into an idle, empty transmitter drives the start bit from E1.
// Backpressure: none on the bus; pushes into a full FIFO are dropped and set the sticky overflow flag.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [10:0] BASE_ADDR   = 11'd101,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic        clk,
    input  logic        reset_,
    input  logic [10:0] m_addr,
    input  logic [7:0]  m_wr_data,
    input  logic        m_wr,
    input  logic        m_rd,
    input  logic        m_en,
    output logic [7:0]  m_rd_data,
    output logic        rd_hit,
    output logic        tx,
    output logic        tx_busy
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // Bus decode: unsigned subtraction wraps addresses below BASE_ADDR out of range
    logic [10:0] off_full;
    logic [2:0]  off;
    logic        in_range;
    logic        wr_en;
    logic        push;

    assign off_full = m_addr - BASE_ADDR;
    assign in_range = (off_full <= 11'd4);
    assign off      = off_full[2:0];
    assign rd_hit   = m_en & m_rd & in_range;
    assign wr_en    = m_en & m_wr & in_range;
    assign push     = wr_en & (off == OFF_TXDATA);

    // Configuration and status registers
    logic [15:0] div_reg;
    logic [3:0]  ctrl;
    logic        overflow;

    // FIFO interface
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          pop;

    // Transmit engine state
    state_t      state;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        par_bit;
    logic [15:0] f_div;
    logic        f_par_en;
    logic        f_two_stop;
    logic        stop2;
    logic        bit_done;
    logic        start_frame;

    assign bit_done    = (baud_cnt == f_div);
    // Start from idle, or chain straight out of the final stop bit so frames run back-to-back
    assign start_frame = ~fifo_empty & ctrl[CTRL_TX_EN] &
                         ((state == S_IDLE) ||
                          ((state == S_STOP) && bit_done && (stop2 || !f_two_stop)));
    assign pop         = start_frame;
    assign tx_busy     = ~fifo_empty | (state != S_IDLE);

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset_ (reset_),
        .push   (push),
        .din    (m_wr_data),
        .pop    (pop),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    // FIFO count for STATUS, saturated to the 4-bit field
    logic [4:0] cnt5;
    logic [3:0] cnt_sat;
    assign cnt5    = 5'(fifo_count);
    assign cnt_sat = cnt5[4] ? 4'hF : cnt5[3:0];

    // Register read mux; combinational so a same-cycle write returns the old value
    always_comb begin
        m_rd_data = 8'd0;
        if (rd_hit) begin
            case (off)
                OFF_TXDATA: m_rd_data = {7'd0, tx_busy};
                OFF_STATUS: m_rd_data = {cnt_sat, overflow, ~fifo_empty & fifo_empty | fifo_empty,
                                         fifo_full, tx_busy};
                OFF_DIV_LO: m_rd_data = div_reg[7:0];
                OFF_DIV_HI: m_rd_data = div_reg[15:8];
                OFF_CTRL:   m_rd_data = {4'd0, ctrl};
                default:    m_rd_data = 8'd0;
            endcase
        end
    end

    // Register writes and sticky overflow
    always_ff @(posedge clk) begin
        if (!reset_) begin
            div_reg  <= DEFAULT_DIV;
            ctrl     <= CTRL_RESET;
            overflow <= 1'b0;
        end else begin
            if (wr_en && off == OFF_DIV_LO) begin
                div_reg[7:0] <= m_wr_data;
            end
            if (wr_en && off == OFF_DIV_HI) begin
                div_reg[15:8] <= m_wr_data;
            end
            if (wr_en && off == OFF_CTRL) begin
                ctrl <= m_wr_data[3:0];
            end
            if (push && fifo_full && !pop) begin
                overflow <= 1'b1;
            end else if (wr_en && off == OFF_STATUS && m_wr_data[ST_OVF]) begin
                overflow <= 1'b0;
            end
        end
    end

    // Transmit FSM with baud counter; frame settings are latched at frame start
    always_ff @(posedge clk) begin
        if (!reset_) begin
            state      <= S_IDLE;
            tx         <= 1'b1;
            baud_cnt   <= 16'd0;
            bit_cnt    <= 3'd0;
            shreg      <= 8'd0;
            par_bit    <= 1'b0;
            f_div      <= DEFAULT_DIV;
            f_par_en   <= 1'b0;
            f_two_stop <= 1'b0;
            stop2      <= 1'b0;
        end else if (start_frame) begin
            state      <= S_START;
            tx         <= 1'b0;
            baud_cnt   <= 16'd0;
            bit_cnt    <= 3'd0;
            shreg      <= fifo_dout;
            par_bit    <= (^fifo_dout) ^ ctrl[CTRL_PAR_ODD];
            f_div      <= div_reg;
            f_par_en   <= ctrl[CTRL_PAR_EN];
            f_two_stop <= ctrl[CTRL_TWO_STOP];
            stop2      <= 1'b0;
        end else if (state != S_IDLE) begin
            if (!bit_done) begin
                baud_cnt <= baud_cnt + 16'd1;
            end else begin
                baud_cnt <= 16'd0;
                case (state)
                    S_START: begin
                        state <= S_DATA;
                        tx    <= shreg[0];
                        shreg <= {1'b0, shreg[7:1]};
                    end
                    S_DATA: begin
                        if (bit_cnt == 3'd7) begin
                            state <= f_par_en ? S_PARITY : S_STOP;
                            tx    <= f_par_en ? par_bit : 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            tx      <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                        end
                    end
                    S_PARITY: begin
                        state <= S_STOP;
                        tx    <= 1'b1;
                    end
                    S_STOP: begin
                        if (f_two_stop && !stop2) begin
                            stop2 <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                            tx    <= 1'b1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: expected reads and serial frames are queued by stimulus.
// Latency: monitors sample on the falling edge, stimulus drives 1 time unit after the rising edge.
// Backpressure: n/a.
module tb_mmio_uart_tx;

    localparam logic [10:0] BASE = 11'd101;

    logic        clk;
    logic        reset_;
    logic [10:0] m_addr;
    logic [7:0]  m_wr_data;
    logic        m_wr;
    logic        m_rd;
    logic        m_en;
    logic [7:0]  m_rd_data;
    logic        rd_hit;
    logic        tx;
    logic        tx_busy;

    mmio_uart_tx #(
        .BASE_ADDR   (BASE),
        .FIFO_DEPTH  (8),
        .DEFAULT_DIV (16'd433)
    ) dut (
        .clk       (clk),
        .reset_    (reset_),
        .m_addr    (m_addr),
        .m_wr_data (m_wr_data),
        .m_wr      (m_wr),
        .m_rd      (m_rd),
        .m_en      (m_en),
        .m_rd_data (m_rd_data),
        .rd_hit    (rd_hit),
        .tx        (tx),
        .tx_busy   (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] data;
        int         div;
        bit         par_en;
        bit         par_bit;
        bit         two_stop;
        bit         no_gap;
        bit         abort;
    } frame_t;

    frame_t     fq[$];
    logic [7:0] rd_q[$];
    string      rdn_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [2:0] off, input logic [7:0] d);
        m_addr    = BASE + 11'(off);
        m_wr_data = d;
        m_en      = 1'b1;
        m_wr      = 1'b1;
        tick();
        m_en      = 1'b0;
        m_wr      = 1'b0;
    endtask

    task automatic bus_rd(input logic [2:0] off, input logic [7:0] e, input string nm);
        m_addr = BASE + 11'(off);
        m_en   = 1'b1;
        m_rd   = 1'b1;
        rd_q.push_back(e);
        rdn_q.push_back(nm);
        tick();
        m_en   = 1'b0;
        m_rd   = 1'b0;
    endtask

    task automatic wait_idle(input int bound, input string tag, output int n);
        n = 0;
        while (tx_busy !== 1'b0 && n < bound) begin
            tick();
            n++;
        end
        chk({"wait_idle_", tag}, tx_busy, 0);
    endtask

    // Read monitor: every bus read hit is compared against the oldest queued expectation
    logic [7:0] rd_exp;
    string      rd_nm;
    always @(negedge clk) begin
        if (rd_hit === 1'b1) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: addr 0x%0h data 0x%0h with no expectation", m_addr, m_rd_data);
            end else begin
                rd_exp = rd_q.pop_front();
                rd_nm  = rdn_q.pop_front();
                chk(rd_nm, m_rd_data, rd_exp);
            end
        end
    end

    // Serial monitor: detects start bits and compares the whole frame clock by clock
    frame_t      rec;
    logic [11:0] bits;
    int          nb;
    int          len;
    int          mism;
    int          idle_cnt;
    int          nfr;
    bit          aborted;
    initial begin : serial_mon
        idle_cnt = 0;
        nfr      = 0;
        forever begin
            @(negedge clk);
            if (reset_ !== 1'b1 || tx !== 1'b0) begin
                if (reset_ === 1'b1) idle_cnt++;
                continue;
            end
            if (fq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame: tx went low with no frame expected");
                while (tx === 1'b0 && reset_ === 1'b1) @(negedge clk);
                idle_cnt = 0;
                continue;
            end
            rec = fq.pop_front();
            nfr++;
            if (rec.no_gap) chk($sformatf("gap_f%0d", nfr), idle_cnt, 0);
            bits    = '1;
            bits[0] = 1'b0;
            for (int k = 0; k < 8; k++) bits[k+1] = rec.data[k];
            nb = 10;
            if (rec.par_en) begin
                bits[9] = rec.par_bit;
                nb = 11;
            end
            if (rec.two_stop) nb++;
            len     = nb * (rec.div + 1);
            mism    = 0;
            aborted = 1'b0;
            for (int i = 0; i < len; i++) begin
                if (i > 0) @(negedge clk);
                if (reset_ !== 1'b1) begin
                    aborted = 1'b1;
                    break;
                end
                if (tx !== bits[i / (rec.div + 1)]) mism++;
            end
            chk($sformatf("frame%0d_abort", nfr), aborted, rec.abort);
            chk($sformatf("frame%0d_bits_%0h", nfr, rec.data), mism, 0);
            idle_cnt = 0;
        end
    end

    // Global time bound
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time bound");
        $fatal(1, "watchdog");
    end

    int n;
    initial begin
        reset_    = 1'b0;
        m_addr    = '0;
        m_wr_data = '0;
        m_wr      = 1'b0;
        m_rd      = 1'b0;
        m_en      = 1'b0;
        tick();
        tick();
        reset_ = 1'b1;
        tick();

        // Reset state
        chk("rst_tx", tx, 1);
        chk("rst_busy", tx_busy, 0);
        bus_rd(OFF1(), 8'h04, "rst_status");
        bus_rd(3'd4, 8'h08, "rst_ctrl");
        bus_rd(3'd2, 8'hB1, "rst_div_lo");
        bus_rd(3'd3, 8'h01, "rst_div_hi");

        // 8N1 with DIV=3: start bit from E1, 40-clock frame
        bus_wr(3'd2, 8'd3);
        bus_wr(3'd3, 8'd0);
        fq.push_back('{8'h55, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        bus_wr(3'd0, 8'h55);                        // E0
        chk("8n1_tx_before_e1", tx, 1);
        tick();                                     // E1
        chk("8n1_start_at_e1", tx, 0);
        bus_rd(3'd0, 8'h01, "compat_busy_poll");    // E2
        bus_rd(3'd1, 8'h05, "8n1_status_mid");      // E3
        repeat (37) tick();                         // E40
        chk("8n1_busy_last_clock", tx_busy, 1);
        tick();                                     // E41
        chk("8n1_busy_fall", tx_busy, 0);
        bus_rd(3'd0, 8'h00, "compat_idle_poll");

        // Odd parity, two stop bits, DIV=1: 0x07 has three ones, parity bit 0, 24 clocks
        bus_wr(3'd2, 8'd1);
        bus_wr(3'd4, 8'h0F);
        fq.push_back('{8'h07, 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        bus_wr(3'd0, 8'h07);
        wait_idle(100, "par", n);
        chk("par_frame_len", n, 25);

        // Overflow with transmitter disabled, then drain back-to-back
        bus_wr(3'd4, 8'h00);
        for (int i = 0; i < 9; i++) bus_wr(3'd0, 8'(160 + i));
        bus_rd(3'd0, 8'h01, "ovf_txdata_busy");
        bus_rd(3'd1, 8'h8B, "ovf_status");
        bus_wr(3'd1, 8'h08);
        bus_rd(3'd1, 8'h83, "ovf_cleared");
        for (int i = 0; i < 8; i++)
            fq.push_back('{8'(160 + i), 1, 1'b0, 1'b0, 1'b0, (i > 0), 1'b0});
        bus_wr(3'd4, 8'h08);
        wait_idle(400, "ovf", n);
        chk("ovf_drain_len", n, 161);

        // Reset during data bit 3; the second queued byte must never go out
        bus_wr(3'd2, 8'd3);
        fq.push_back('{8'hC3, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        bus_wr(3'd0, 8'hC3);                        // E0
        bus_wr(3'd0, 8'h3C);                        // E1
        repeat (17) tick();                         // E18, inside bit 3
        reset_ = 1'b0;
        tick();
        chk("rst_mid_tx", tx, 1);
        tick();
        reset_ = 1'b1;
        tick();
        bus_rd(3'd1, 8'h04, "rst_mid_status");
        bus_rd(3'd2, 8'hB1, "rst_mid_div_lo");
        repeat (60) tick();
        chk("rst_mid_no_frame", tx_busy, 0);

        // Decode edges: one past the map and one below it
        m_addr = BASE + 11'd5;
        m_en   = 1'b1;
        m_rd   = 1'b1;
        #1;
        chk("rd_hit_base_plus5", rd_hit, 0);
        chk("rd_data_base_plus5", m_rd_data, 0);
        m_addr = BASE - 11'd1;
        #1;
        chk("rd_hit_base_minus1", rd_hit, 0);
        m_en = 1'b0;
        m_rd = 1'b0;
        tick();

        // Simultaneous read and write returns the pre-write value
        m_addr    = BASE + 11'd2;
        m_wr_data = 8'h22;
        m_en      = 1'b1;
        m_wr      = 1'b1;
        m_rd      = 1'b1;
        rd_q.push_back(8'hB1);
        rdn_q.push_back("rw_same_cycle_old");
        tick();
        m_en = 1'b0;
        m_wr = 1'b0;
        m_rd = 1'b0;
        bus_rd(3'd2, 8'h22, "rw_new_value");

        repeat (5) tick();
        chk("read_queue_drained", rd_q.size(), 0);
        chk("frame_queue_drained", fq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    function automatic logic [2:0] OFF1();
        return 3'd1;
    endfunction

endmodule
